// File: rtl/target_max_scheduler_if.sv
// Port bundle for target_max_scheduler: Q-value input stream, shared-adder issue/return, and result.
// Input stream: a word transfers on a clock edge where i_valid && i_ready. Adder: o_add_valid is a 1-cycle issue, i_add_valid a 1-cycle return.
interface target_max_scheduler_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 2
);
  logic                   i_valid;
  logic [DATA_WIDTH-1:0]  i_data;
  logic                   i_ready;
  logic                   o_add_valid;
  logic [DATA_WIDTH-1:0]  o_add_a;
  logic [DATA_WIDTH-1:0]  o_add_b;
  logic                   i_add_valid;
  logic [DATA_WIDTH-1:0]  i_add_data;
  logic [DATA_WIDTH-1:0]  o_data;
  logic [INDEX_WIDTH-1:0] o_index;
  logic                   o_valid;
  logic                   o_busy;
  logic [2:0]             dbg_state;

  modport slave (
    input  i_valid, i_data, i_add_valid, i_add_data,
    output i_ready, o_add_valid, o_add_a, o_add_b, o_data, o_index, o_valid, o_busy, dbg_state
  );

  modport master (
    output i_valid, i_data, i_add_valid, i_add_data,
    input  i_ready, o_add_valid, o_add_a, o_add_b, o_data, o_index, o_valid, o_busy, dbg_state
  );
endinterface

// File: rtl/target_max_scheduler.sv
// Buffers N float Q values, then finds max/argmax by issuing (max - candidate) to a shared
// external float adder one operation at a time and testing the sign of the difference.
module target_max_scheduler #(
  parameter int DATA_WIDTH            = 32,
  parameter int NUMBER_OF_OUTPUT_NODE = 3,
  parameter int INDEX_WIDTH           = 2,
  parameter int ADDER_LATENCY         = 7
) (
  input logic                    clk,
  input logic                    rst_n,
  target_max_scheduler_if.slave  bus
);

  localparam int MSB = DATA_WIDTH - 1;
  localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(NUMBER_OF_OUTPUT_NODE - 1);

  if (NUMBER_OF_OUTPUT_NODE < 1 || (2 ** INDEX_WIDTH) < NUMBER_OF_OUTPUT_NODE ||
      ADDER_LATENCY < 1) begin : g_bad_params
    $error("target_max_scheduler: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [INDEX_WIDTH-1:0]  cnt_q;
  logic [INDEX_WIDTH-1:0]  cand_q;
  logic [DATA_WIDTH-1:0]   max_q;
  logic [INDEX_WIDTH-1:0]  idx_q;
  logic [DATA_WIDTH-1:0]   res_data_q;
  logic [INDEX_WIDTH-1:0]  res_idx_q;
  logic [DATA_WIDTH-1:0]   word_buf [2**INDEX_WIDTH];

  logic                    loading;
  logic                    accept;
  logic                    last_word;
  logic                    in_flight;
  logic                    add_done;
  logic                    replace;
  logic [DATA_WIDTH-1:0]   cand_word;

  assign loading   = (state_q == IDLE) || (state_q == LOAD);
  assign accept    = loading && bus.i_valid;
  assign last_word = (cnt_q == LAST);
  assign in_flight = (state_q == ISSUE) || (state_q == WAIT);
  assign add_done  = (state_q == WAIT) && bus.i_add_valid;
  assign cand_word = word_buf[cand_q];
  // A strictly negative, non-zero difference means the candidate is larger; +/-0 keeps the lower index.
  assign replace   = bus.i_add_data[MSB] && (bus.i_add_data[MSB-1:0] != '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, LOAD: begin
        if (bus.i_valid) begin
          if (!last_word)                      state_d = LOAD;
          else if (NUMBER_OF_OUTPUT_NODE == 1) state_d = DONE;
          else                                 state_d = ISSUE;
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.i_add_valid) state_d = (cand_q == LAST) ? DONE : ISSUE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      cand_q     <= '0;
      max_q      <= '0;
      idx_q      <= '0;
      res_data_q <= '0;
      res_idx_q  <= '0;
    end else begin
      if (accept) begin
        cnt_q  <= last_word ? '0 : cnt_q + 1'b1;
        cand_q <= INDEX_WIDTH'(1);
        if (state_q == IDLE) begin
          max_q <= bus.i_data;
          idx_q <= '0;
        end
      end
      if (add_done) begin
        cand_q <= cand_q + 1'b1;
        if (replace) begin
          max_q <= cand_word;
          idx_q <= cand_q;
        end
      end
      if (state_q == DONE) begin
        res_data_q <= max_q;
        res_idx_q  <= idx_q;
      end
    end
  end

  // Buffer contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (accept) word_buf[cnt_q] <= bus.i_data;
  end

  assign bus.i_ready     = loading;
  assign bus.o_busy      = (state_q != IDLE);
  assign bus.o_add_valid = (state_q == ISSUE);
  assign bus.o_add_a     = in_flight ? max_q : '0;
  assign bus.o_add_b     = in_flight ? {~cand_word[MSB], cand_word[MSB-1:0]} : '0;
  assign bus.o_valid     = (state_q == DONE);
  assign bus.o_data      = (state_q == DONE) ? max_q : res_data_q;
  assign bus.o_index     = (state_q == DONE) ? idx_q : res_idx_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_target_max_scheduler.sv
// Directed bench for target_max_scheduler: behavioural float adder model, expected-result
// queues filled by the stimulus, and a monitor that pops them whenever o_valid fires.
module tb_target_max_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  target_max_scheduler_if #(.DATA_WIDTH(32), .INDEX_WIDTH(2)) bus ();
  target_max_scheduler_if #(.DATA_WIDTH(32), .INDEX_WIDTH(2)) bus1 ();

  target_max_scheduler #(
    .DATA_WIDTH(32), .NUMBER_OF_OUTPUT_NODE(3), .INDEX_WIDTH(2), .ADDER_LATENCY(7)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  target_max_scheduler #(
    .DATA_WIDTH(32), .NUMBER_OF_OUTPUT_NODE(1), .INDEX_WIDTH(2), .ADDER_LATENCY(7)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // float helpers for the adder model (normal numbers and zero are enough here)
  function automatic real f2r(input logic [31:0] f);
    real m;
    int  e;
    e = int'(f[30:23]);
    if (e == 0) return 0.0;
    m = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Shared adder model: latency 7 from o_add_valid to i_add_valid.
  logic        add_pend = 1'b0;
  int          add_due = 0;
  int          add_issues = 0;
  logic [31:0] add_a, add_b, last_b;

  always @(negedge clk) begin
    bus.i_add_valid = 1'b0;
    if (!rst_n) add_pend = 1'b0;
    if (add_pend && cyc == add_due) begin
      bus.i_add_valid = 1'b1;
      bus.i_add_data  = r2f(f2r(add_a) + f2r(add_b));
      add_pend = 1'b0;
    end
    if (rst_n && bus.o_add_valid) begin
      if (add_pend) check("adder_overlap", 32'd1, 32'd0);
      add_pend = 1'b1;
      add_due  = cyc + 7;
      add_a    = bus.o_add_a;
      add_b    = bus.o_add_b;
      last_b   = bus.o_add_b;
      add_issues++;
    end
  end

  // Scoreboard
  logic [31:0] exp_q[$];
  logic [1:0]  exp_idx_q[$];
  int          exp_cyc_q[$];
  logic [31:0] exp1_q[$];
  int          exp1_cyc_q[$];
  int          got_cnt = 0;
  int          n1_add_seen = 0;

  always @(negedge clk) begin
    if (rst_n && bus.o_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_o_valid", 32'd1, 32'd0);
      end else begin
        check("o_data", bus.o_data, exp_q.pop_front());
        check("o_index", 32'(bus.o_index), 32'(exp_idx_q.pop_front()));
        check("latency", cyc, exp_cyc_q.pop_front());
      end
      got_cnt++;
    end
    if (rst_n && bus1.o_add_valid) n1_add_seen++;
    if (rst_n && bus1.o_valid) begin
      if (exp1_q.size() == 0) begin
        check("n1_unexpected_o_valid", 32'd1, 32'd0);
      end else begin
        check("n1_o_data", bus1.o_data, exp1_q.pop_front());
        check("n1_o_index", 32'(bus1.o_index), 32'd0);
        check("n1_latency", cyc, exp1_cyc_q.pop_front());
      end
    end
  end

  // Drivers: called at a negedge; words presented with given idle gaps after word 0 and 1.
  task automatic load3(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                       input int g0, input int g1, output int last_cyc);
    logic [31:0] w [3];
    int          g [3];
    w[0] = w0; w[1] = w1; w[2] = w2;
    g[0] = g0; g[1] = g1; g[2] = 0;
    last_cyc = 0;
    for (int i = 0; i < 3; i++) begin
      check("load_ready", 32'(bus.i_ready), 32'd1);
      bus.i_valid = 1'b1;
      bus.i_data  = w[i];
      last_cyc    = cyc;
      @(negedge clk);
      bus.i_valid = 1'b0;
      repeat (g[i]) @(negedge clk);
    end
  endtask

  task automatic expect_result(input logic [31:0] d, input logic [1:0] idx, input int at_cyc);
    exp_q.push_back(d);
    exp_idx_q.push_back(idx);
    exp_cyc_q.push_back(at_cyc);
  endtask

  task automatic wait_result();
    int start;
    bit seen;
    start = got_cnt;
    seen  = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (got_cnt > start) seen = 1'b1;
    end
    if (!seen) check("result_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_issues(input int target);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (add_issues >= target) seen = 1'b1;
    end
    if (!seen) check("issue_timeout", 32'(add_issues), 32'(target));
  endtask

  initial begin
    int last_cyc;
    int base;
    int got_before;
    bus.i_valid = 1'b0;  bus.i_data = '0;
    bus1.i_valid = 1'b0; bus1.i_data = '0;
    bus1.i_add_valid = 1'b0; bus1.i_add_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_i_ready", 32'(bus.i_ready), 32'd1);
    check("rst_o_add_valid", 32'(bus.o_add_valid), 32'd0);
    check("rst_o_add_a", bus.o_add_a, 32'd0);
    check("rst_o_add_b", bus.o_add_b, 32'd0);
    check("rst_o_valid", 32'(bus.o_valid), 32'd0);
    check("rst_o_data", bus.o_data, 32'd0);
    check("rst_o_index", 32'(bus.o_index), 32'd0);
    check("rst_o_busy", 32'(bus.o_busy), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'd0);
    check("rst_n1_i_ready", 32'(bus1.i_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // {1.0, 2.5, -3.0} back to back
    load3(32'h3F800000, 32'h40200000, 32'hC0400000, 0, 0, last_cyc);
    check("busy_after_load", 32'(bus.o_busy), 32'd1);
    expect_result(32'h40200000, 2'd1, last_cyc + 17);
    wait_result();
    repeat (3) @(negedge clk);
    check("hold_o_data", bus.o_data, 32'h40200000);
    check("hold_o_index", 32'(bus.o_index), 32'd1);
    check("idle_busy", 32'(bus.o_busy), 32'd0);

    // {-3.0, -1.0, 0.0}: first issue carries +1.0 as operand B
    base = add_issues;
    load3(32'hC0400000, 32'hBF800000, 32'h00000000, 0, 0, last_cyc);
    expect_result(32'h00000000, 2'd2, last_cyc + 17);
    wait_issues(base + 1);
    check("first_o_add_b", last_b, 32'h3F800000);
    wait_result();

    // Ties: lower index wins
    load3(32'h40000000, 32'h40000000, 32'h3F800000, 0, 0, last_cyc);
    expect_result(32'h40000000, 2'd0, last_cyc + 17);
    wait_result();

    // Gaps (1,0,0,1,0,1) plus i_valid pulses while waiting on the adder
    base = add_issues;
    load3(32'h3F800000, 32'h40200000, 32'hC0400000, 2, 1, last_cyc);
    expect_result(32'h40200000, 2'd1, last_cyc + 17);
    wait_issues(base + 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ready_in_wait", 32'(bus.i_ready), 32'd0);
      bus.i_valid = 1'b1;
      bus.i_data  = 32'h7F000000;
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    wait_result();

    // Reset while waiting on the second compare
    base = add_issues;
    got_before = got_cnt;
    load3(32'h3F800000, 32'h40200000, 32'hC0400000, 0, 0, last_cyc);
    wait_issues(base + 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_i_ready", 32'(bus.i_ready), 32'd1);
    check("mid_rst_o_add_valid", 32'(bus.o_add_valid), 32'd0);
    check("mid_rst_o_add_a", bus.o_add_a, 32'd0);
    check("mid_rst_o_add_b", bus.o_add_b, 32'd0);
    check("mid_rst_o_valid", 32'(bus.o_valid), 32'd0);
    check("mid_rst_o_data", bus.o_data, 32'd0);
    check("mid_rst_o_index", 32'(bus.o_index), 32'd0);
    check("mid_rst_o_busy", 32'(bus.o_busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_o_valid_after_rst", 32'(got_cnt), 32'(got_before));
    load3(32'h3F800000, 32'h40200000, 32'hC0400000, 0, 0, last_cyc);
    expect_result(32'h40200000, 2'd1, last_cyc + 17);
    wait_result();

    // N=1 instance: result one cycle after acceptance, adder never used
    check("n1_ready", 32'(bus1.i_ready), 32'd1);
    bus1.i_valid = 1'b1;
    bus1.i_data  = 32'h41200000;
    exp1_q.push_back(32'h41200000);
    exp1_cyc_q.push_back(cyc + 1);
    @(negedge clk);
    bus1.i_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("n1_hold_o_data", bus1.o_data, 32'h41200000);
    check("n1_no_add_issue", 32'(n1_add_seen), 32'd0);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("exp1_q_drained", 32'(exp1_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got %0d checks, expected completion", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/target_max_scheduler.md
Name: target_max_scheduler

Overview:
- Sequential max/argmax controller for the target network's Q-value outputs.
- Buffers NUMBER_OF_OUTPUT_NODE IEEE-754 single-precision words streamed from the target network output stage.
- Schedules pairwise comparisons through one externally instantiated, shared adder_floating_point32 (fixed latency, valid-in/valid-out) using a subtract-and-sign test.
- Returns the maximum Q value and its action index to the DQN loss/update stage.

Parameters:
- DATA_WIDTH, 32, float word width (IEEE-754 single).
- NUMBER_OF_OUTPUT_NODE, 3, number of Q values per search (N ≥ 1).
- INDEX_WIDTH, 2, width of the action index; must satisfy 2^INDEX_WIDTH ≥ N.
- ADDER_LATENCY, 7, cycles from o_add_valid to i_add_valid on the shared adder.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  input word valid
- i_data  in  DATA_WIDTH  Q value, presented in index order 0..N-1
- i_ready  out  1  block accepts a word this cycle
- o_add_valid  out  1  one-cycle issue strobe to the shared adder
- o_add_a  out  DATA_WIDTH  adder operand A: current max
- o_add_b  out  DATA_WIDTH  adder operand B: candidate with sign bit inverted
- i_add_valid  in  1  adder result valid
- i_add_data  in  DATA_WIDTH  adder result (A − candidate)
- o_data  out  DATA_WIDTH  maximum Q value
- o_index  out  INDEX_WIDTH  index of the maximum
- o_valid  out  1  one-cycle result strobe
- o_busy  out  1  high from the first accepted word until o_valid

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; load count=0; all outputs 0 except i_ready=1. Internal buffer contents are don't-care. Reset mid-operation aborts the search with no o_valid.
- FSM states: IDLE, LOAD, ISSUE, WAIT, DONE.
- IDLE/LOAD: i_ready=1. Each cycle with i_valid=1 writes i_data to buf[count] and increments count. The first accepted word also initializes max=buf[0] and idx=0, then the FSM enters LOAD.
- After the N-th word is accepted: if N=1, go to DONE; otherwise go to ISSUE with cand=1.
- ISSUE (1 cycle): o_add_valid=1, o_add_a=max, o_add_b={~buf[cand][MSB], buf[cand][MSB-1:0]}; go to WAIT.
- WAIT: hold until i_add_valid=1. Replace rule: replace iff i_add_data[MSB]=1 and i_add_data[MSB-1:0]≠0; on replace, max=buf[cand] and idx=cand. Ties and ±0 differences keep the lower index.
  - cand=N-1: go to DONE.
  - Otherwise: cand++ and go to ISSUE.
- DONE (1 cycle): o_valid=1; o_data=max; o_index=idx; then go to IDLE.
- o_data and o_index hold their values after o_valid until the next DONE.
- Latency: the last word accepted at cycle c gives o_valid at c+1+(N−1)·(ADDER_LATENCY+1). For N=3 and latency 7, this is c+17.
- Adder handshake:
  - Only one operation is in flight at a time.
  - o_add_a and o_add_b are held stable from ISSUE until i_add_valid.
  - i_add_valid outside WAIT is ignored.
- i_ready=0 in ISSUE, WAIT and DONE; i_valid in those states is dropped and not buffered.
- Word gaps: i_valid may deassert between words in LOAD; the load count is retained.
- o_busy=1 in LOAD, ISSUE, WAIT and DONE.
- NaN inputs have undefined ordering but must not hang the FSM.

Test Plan:
- Load {3F800000 (1.0), 40200000 (2.5), C0400000 (−3.0)} back to back, with the adder model at latency 7 → o_valid exactly 17 cycles after the third word; o_data=40200000, o_index=1.
- Load {C0400000, BF800000 (−1.0), 00000000} → o_data=00000000, o_index=2. Check that o_add_b on the first issue is 3F800000.
- Ties {40000000, 40000000, 3F800000} → o_index=0, o_data=40000000 (lower index wins).
- Load with gaps (i_valid 1,0,0,1,0,1), and i_valid pulses during WAIT → i_ready=0 during WAIT, extra words ignored, result matches the gap-free run.
- Assert rst_n=0 during WAIT of the second compare → all outputs 0 at once, i_ready=1, no o_valid. A following clean search {1.0, 2.5, −3.0} returns 40200000 with index 1.
- Run with N=1 and parameter override, load 41200000 → o_valid one cycle after acceptance, o_index=0, o_add_valid never asserted.
